motor_guard: RTL

//  Sits between the drive controller and the L298-style H-bridge enables.

---
 rtl/motor_guard_pkg.sv | 14 +
 rtl/oc_channel.sv | 117 +++++++++++
 rtl/motor_guard.sv | 92 +++++++++
 3 files changed

// File: rtl/motor_guard_pkg.sv
// Shared definitions for motor_guard: channel state encoding and status field widths.
package motor_guard_pkg;

  localparam int STATE_W = 2;
  localparam int TRIPS_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_RUN  = 2'd0,
    ST_TRIP = 2'd1,
    ST_COOL = 2'd2,
    ST_LOCK = 2'd3
  } chan_state_e;

endpackage

// File: rtl/oc_channel.sv
// One guarded H-bridge channel: OC synchroniser, debounce, trip/cooldown/lockout FSM and EN gate.
module oc_channel
  import motor_guard_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1000,
  parameter int COOLDOWN_CYC = 50_000_000,
  parameter int MAX_RETRY    = 3
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_pwm,
  input  logic               i_oc,
  input  logic               i_clearFault,
  output logic               o_en,
  output logic [STATE_W-1:0] o_state,
  output logic [TRIPS_W-1:0] o_trips,
  output logic               o_lockNext
);

  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam int CD_W = $clog2(COOLDOWN_CYC + 1);
  localparam logic [DB_W-1:0]    DB_MAX     = DB_W'(DEBOUNCE_CYC);
  localparam logic [CD_W-1:0]    CD_RELOAD  = CD_W'(COOLDOWN_CYC - 1);
  localparam logic [TRIPS_W-1:0] TRIP_LIMIT = TRIPS_W'(MAX_RETRY);

  logic               r_sync1;
  logic               r_sync2;
  logic [DB_W-1:0]    r_dbCnt;
  logic               w_ocValid;
  chan_state_e        r_state;
  chan_state_e        w_stateNext;
  logic [TRIPS_W-1:0] r_trips;
  logic [TRIPS_W-1:0] w_tripsNext;
  logic [TRIPS_W-1:0] w_tripsInc;
  logic [CD_W-1:0]    r_cool;
  logic [CD_W-1:0]    w_coolNext;
  logic               r_en;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_dbCnt <= '0;
    end else begin
      r_sync1 <= i_oc;
      r_sync2 <= r_sync1;
      if (!r_sync2) begin
        r_dbCnt <= '0;
      end else if (r_dbCnt != DB_MAX) begin
        r_dbCnt <= r_dbCnt + 1'b1;
      end
    end
  end

  assign w_ocValid  = (r_dbCnt == DB_MAX);
  assign w_tripsInc = r_trips + 1'b1;

  always_comb begin
    w_stateNext = r_state;
    w_tripsNext = r_trips;
    w_coolNext  = r_cool;
    case (r_state)
      ST_RUN: begin
        if (w_ocValid) begin
          w_stateNext = ST_TRIP;
        end else if (i_clearFault) begin
          w_tripsNext = '0;
        end
      end
      ST_TRIP: begin
        w_tripsNext = w_tripsInc;
        if (w_tripsInc == TRIP_LIMIT) begin
          w_stateNext = ST_LOCK;
        end else begin
          w_stateNext = ST_COOL;
          w_coolNext  = CD_RELOAD;
        end
      end
      ST_COOL: begin
        if (r_cool == '0) begin
          w_stateNext = w_ocValid ? ST_TRIP : ST_RUN;
        end else begin
          w_coolNext = r_cool - 1'b1;
        end
      end
      ST_LOCK: begin
        if (i_clearFault) begin
          w_tripsNext = '0;
          w_stateNext = ST_COOL;
          w_coolNext  = CD_RELOAD;
        end
      end
      default: w_stateNext = ST_RUN;
    endcase
  end

  // EN follows the next state so a trip blanks the output on the same edge it is taken.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_RUN;
      r_trips <= '0;
      r_cool  <= '0;
      r_en    <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_trips <= w_tripsNext;
      r_cool  <= w_coolNext;
      r_en    <= (w_stateNext == ST_RUN) && i_pwm;
    end
  end

  assign o_en       = r_en;
  assign o_state    = r_state;
  assign o_trips    = r_trips;
  assign o_lockNext = (w_stateNext == ST_LOCK);

endmodule

// File: rtl/motor_guard.sv
// Dual-channel H-bridge enable guard: shared PWM generator feeding two independent OC-protected channels.
module motor_guard
  import motor_guard_pkg::*;
#(
  parameter int PWM_BITS     = 8,
  parameter int PRESCALE     = 16,
  parameter int DEBOUNCE_CYC = 1000,
  parameter int COOLDOWN_CYC = 50_000_000,
  parameter int MAX_RETRY    = 3
) (
  input  logic                CLK100MHZ,
  input  logic                rst_n,
  input  logic [PWM_BITS-1:0] duty_a,
  input  logic [PWM_BITS-1:0] duty_b,
  input  logic                OCA,
  input  logic                OCB,
  input  logic                clear_fault,
  output logic                ENA,
  output logic                ENB,
  output logic [STATE_W-1:0]  state_a,
  output logic [STATE_W-1:0]  state_b,
  output logic [TRIPS_W-1:0]  trips_a,
  output logic [TRIPS_W-1:0]  trips_b,
  output logic                fault
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0]     r_presc;
  logic [PWM_BITS-1:0] r_pwmCnt;
  logic                r_fault;
  logic                w_tick;
  logic                w_pwmA;
  logic                w_pwmB;
  logic                w_lockNextA;
  logic                w_lockNextB;

  assign w_tick = (r_presc == PS_LAST);

  // The PWM counter wraps naturally at 2^PWM_BITS; with PRESCALE=1 it steps every clock.
  always_ff @(posedge CLK100MHZ) begin
    if (!rst_n) begin
      r_presc  <= '0;
      r_pwmCnt <= '0;
      r_fault  <= 1'b0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) begin
        r_pwmCnt <= r_pwmCnt + 1'b1;
      end
      r_fault <= w_lockNextA | w_lockNextB;
    end
  end

  assign w_pwmA = (r_pwmCnt < duty_a);
  assign w_pwmB = (r_pwmCnt < duty_b);
  assign fault  = r_fault;

  oc_channel #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .COOLDOWN_CYC(COOLDOWN_CYC),
    .MAX_RETRY   (MAX_RETRY)
  ) u_chanA (
    .i_clk       (CLK100MHZ),
    .i_rst_n     (rst_n),
    .i_pwm       (w_pwmA),
    .i_oc        (OCA),
    .i_clearFault(clear_fault),
    .o_en        (ENA),
    .o_state     (state_a),
    .o_trips     (trips_a),
    .o_lockNext  (w_lockNextA)
  );

  oc_channel #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .COOLDOWN_CYC(COOLDOWN_CYC),
    .MAX_RETRY   (MAX_RETRY)
  ) u_chanB (
    .i_clk       (CLK100MHZ),
    .i_rst_n     (rst_n),
    .i_pwm       (w_pwmB),
    .i_oc        (OCB),
    .i_clearFault(clear_fault),
    .o_en        (ENB),
    .o_state     (state_b),
    .o_trips     (trips_b),
    .o_lockNext  (w_lockNextB)
  );

endmodule
